// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Holds the FSM state type, the one-hot decoder and the burst beat counter width.
package regbank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Wide enough for any MAXBURST in 1..15.
   localparam int BEAT_W = 4;

   localparam int OH_IW = 6;
   localparam int OH_W  = 1 << OH_IW;

   // Callers keep only the low bits they need.
   function automatic logic [OH_W-1:0] onehot(input logic [OH_IW-1:0] idx);
      logic [OH_W-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   winner,
   output logic            valid
);

   logic [IW-1:0] idx;

   // Scan from the farthest offset down so the nearest hit to ptr is the last one written.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         idx = IW'((int'(ptr) + off) % NREQ);
         if (req[idx]) begin
            winner = idx;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter for the register bank with locked bursts.
// Drives a registered grant, one-hot write enable and shared data bus.
module regbank_write_arbiter
   import regbank_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int NREQ     = 3,
   parameter int NREG     = 4,
   parameter int MAXBURST = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_lock,
   input  logic [NREQ*$clog2(NREG)-1:0] req_addr,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic [NREQ-1:0]          gnt,
   output logic [WIDTH-1:0]         DATA,
   output logic [NREG-1:0]          WE,
   output logic                     busy
);

   localparam int AW = $clog2(NREG);
   localparam int IW = $clog2(NREQ);

   state_t              state_q, state_n;
   logic [IW-1:0]       ptr_q, ptr_n;
   logic [IW-1:0]       owner_q, owner_n;
   logic [BEAT_W-1:0]   beat_q, beat_n;
   logic [IW-1:0]       pick_ptr;
   logic [IW-1:0]       winner;
   logic                valid;
   logic                hold;
   logic                grant;
   logic [IW-1:0]       sel;
   logic [OH_W-1:0]     gnt_oh, we_oh;
   logic [NREQ-1:0]     gnt_n;
   logic [NREG-1:0]     we_n;
   logic [WIDTH-1:0]    data_n;
   logic                unused_oh;

   function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
      return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
   endfunction

   // On release the owner becomes lowest priority for the same-edge arbitration.
   assign pick_ptr = (state_q == BURST) ? inc_mod(owner_q) : ptr_q;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (winner),
      .valid  (valid)
   );

   assign hold = (state_q == BURST) && req[owner_q] && req_lock[owner_q] &&
                 (beat_q < BEAT_W'(MAXBURST));

   always_comb begin
      state_n = IDLE;
      ptr_n   = pick_ptr;
      owner_n = owner_q;
      beat_n  = '0;
      sel     = winner;
      grant   = valid;
      if (hold) begin
         state_n = BURST;
         ptr_n   = ptr_q;
         sel     = owner_q;
         grant   = 1'b1;
         beat_n  = beat_q + 1'b1;
      end else if (valid) begin
         if (req_lock[winner] && (MAXBURST > 1)) begin
            state_n = BURST;
            owner_n = winner;
            beat_n  = BEAT_W'(1);
         end else begin
            ptr_n = inc_mod(winner);
         end
      end

      gnt_oh = onehot(OH_IW'(sel));
      we_oh  = onehot(OH_IW'(req_addr[int'(sel)*AW +: AW]));
      gnt_n  = grant ? gnt_oh[NREQ-1:0] : '0;
      we_n   = grant ? we_oh[NREG-1:0]  : '0;
      data_n = grant ? req_data[int'(sel)*WIDTH +: WIDTH] : DATA;
   end

   assign unused_oh = ^{gnt_oh[OH_W-1:NREQ], we_oh[OH_W-1:NREG]};

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         beat_q  <= '0;
         gnt     <= '0;
         WE      <= '0;
         DATA    <= '0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         owner_q <= owner_n;
         beat_q  <= beat_n;
         gnt     <= gnt_n;
         WE      <= we_n;
         DATA    <= data_n;
      end
   end

   assign busy = (state_q == BURST);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter (WIDTH=4, NREQ=3, NREG=4, MAXBURST=4).
module tb_regbank_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [2:0]  req_lock;
   logic [5:0]  req_addr;
   logic [11:0] req_data;
   logic [2:0]  gnt;
   logic [3:0]  DATA;
   logic [3:0]  WE;
   logic        busy;

   logic [3:0]  regs [4];
   int          tests  = 0;
   int          failed = 0;

   regbank_write_arbiter #(
      .WIDTH    (4),
      .NREQ     (3),
      .NREG     (4),
      .MAXBURST (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_lock (req_lock),
      .req_addr (req_addr),
      .req_data (req_data),
      .gnt      (gnt),
      .DATA     (DATA),
      .WE       (WE),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Stand-in for the register instances fed by WE/DATA.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (WE[i]) regs[i] <= DATA;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic [2:0] g, input logic [3:0] w,
                             input logic [3:0] d, input logic b);
      check({tag, ".gnt"},  32'(gnt),  32'(g));
      check({tag, ".we"},   32'(WE),   32'(w));
      check({tag, ".data"}, 32'(DATA), 32'(d));
      check({tag, ".busy"}, 32'(busy), 32'(b));
   endtask

   initial begin
      reset    = 1'b0;
      req      = '0;
      req_lock = '0;
      req_addr = '0;
      req_data = '0;
      repeat (2) @(negedge clk);
      expect_out("reset", 3'b000, 4'b0000, 4'h0, 1'b0);
      reset = 1'b1;

      // Round robin from ptr=0: addr i+1, data i+1 for requester i.
      req = 3'b111;
      req_addr = {2'd3, 2'd2, 2'd1};
      req_data = {4'h3, 4'h2, 4'h1};
      cyc(); expect_out("rr0", 3'b001, 4'b0010, 4'h1, 1'b0);
      cyc(); expect_out("rr1", 3'b010, 4'b0100, 4'h2, 1'b0);
      cyc(); expect_out("rr2", 3'b100, 4'b1000, 4'h3, 1'b0);
      cyc(); expect_out("rr3", 3'b001, 4'b0010, 4'h1, 1'b0);

      // Single write: requester 1, register 2, data A.
      req = 3'b010;
      req_data[7:4] = 4'hA;
      cyc(); expect_out("single", 3'b010, 4'b0100, 4'hA, 1'b0);
      req = 3'b000;
      cyc();
      check("single.reg2", 32'(regs[2]), 32'hA);
      expect_out("single.idle", 3'b000, 4'b0000, 4'hA, 1'b0);

      // Idle hold after a write of 5 to register 0 from requester 2.
      req = 3'b100;
      req_addr[5:4] = 2'd0;
      req_data[11:8] = 4'h5;
      cyc(); expect_out("hold.wr", 3'b100, 4'b0001, 4'h5, 1'b0);
      req = 3'b000;
      cyc(); expect_out("hold.i0", 3'b000, 4'b0000, 4'h5, 1'b0);
      cyc(); expect_out("hold.i1", 3'b000, 4'b0000, 4'h5, 1'b0);
      check("hold.reg0", 32'(regs[0]), 32'h5);

      // Locked burst cap: requester 0 locked, everyone requesting, ptr=0.
      req = 3'b111;
      req_lock = 3'b001;
      req_addr[1:0] = 2'd3;
      req_data[3:0] = 4'h6;
      cyc(); expect_out("cap.b1", 3'b001, 4'b1000, 4'h6, 1'b1);
      req_data[3:0] = 4'h7;
      cyc(); expect_out("cap.b2", 3'b001, 4'b1000, 4'h7, 1'b1);
      cyc(); expect_out("cap.b3", 3'b001, 4'b1000, 4'h7, 1'b1);
      cyc(); expect_out("cap.b4", 3'b001, 4'b1000, 4'h7, 1'b1);
      cyc(); expect_out("cap.rel", 3'b010, 4'b0100, 4'hA, 1'b0);
      req = 3'b000;
      req_lock = 3'b000;
      cyc(); expect_out("cap.idle", 3'b000, 4'b0000, 4'hA, 1'b0);

      // Early release: ptr=2, requester 2 locked, requester 0 pending.
      req = 3'b101;
      req_lock = 3'b100;
      req_data[11:8] = 4'h9;
      cyc(); expect_out("early.b1", 3'b100, 4'b0001, 4'h9, 1'b1);
      cyc(); expect_out("early.b2", 3'b100, 4'b0001, 4'h9, 1'b1);
      req_lock = 3'b000;
      cyc(); expect_out("early.rel", 3'b001, 4'b1000, 4'h7, 1'b0);
      cyc(); expect_out("early.next", 3'b100, 4'b0001, 4'h9, 1'b0);
      req = 3'b000;
      cyc(); expect_out("early.idle", 3'b000, 4'b0000, 4'h9, 1'b0);

      // Reset in the middle of a requester-1 burst at beat 2.
      req = 3'b010;
      req_lock = 3'b010;
      cyc(); expect_out("rst.b1", 3'b010, 4'b0100, 4'hA, 1'b1);
      cyc(); expect_out("rst.b2", 3'b010, 4'b0100, 4'hA, 1'b1);
      reset = 1'b0;
      #1;
      expect_out("rst.async", 3'b000, 4'b0000, 4'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      req = 3'b001;
      req_lock = 3'b000;
      cyc(); expect_out("rst.first", 3'b001, 4'b1000, 4'h7, 1'b0);

      // Work-conserving: lone requester granted every cycle.
      cyc(); expect_out("wc1", 3'b001, 4'b1000, 4'h7, 1'b0);
      cyc(); expect_out("wc2", 3'b001, 4'b1000, 4'h7, 1'b0);
      req = 3'b000;
      cyc(); expect_out("end.idle", 3'b000, 4'b0000, 4'h7, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin write-port arbiter for the processor's register bank. It grants one of NREQ write requesters per cycle, and drives the shared DATA bus and a one-hot WE vector into NREG register_B-style registers. Locked bursts of up to MAXBURST back-to-back writes are supported. The block sits between the requesters (control unit, load path, debug port) and the register instances.

## Interface
- WIDTH, 4: data width, equal to the register width
- NREQ, 3: number of requesters (2..8)
- NREG, 4: number of registers, power of two; AW = log2(NREG)
- MAXBURST, 4: maximum consecutive locked grants (1..15)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request
- req_lock  in  NREQ  per-requester burst lock; sampled with req
- req_addr  in  NREQ*AW  target register; requester i uses slice [i*AW +: AW]
- req_data  in  NREQ*WIDTH  write data; requester i uses slice [i*WIDTH +: WIDTH]
- gnt  out  NREQ  registered one-hot grant; all zero when no grant
- DATA  out  WIDTH  registered write data to all registers
- WE  out  NREG  registered one-hot write enable; WE[a] feeds register a
- busy  out  1  high while in BURST

## Operation
- States:
  - IDLE: arbitrate every cycle.
  - BURST: hold the grant on the locked owner.
- Arbitration (IDLE): the winner is the first asserted req scanning from ptr upward, modulo NREQ.
  - ptr resets to 0.
  - ptr becomes winner+1 (mod NREQ) on every non-burst grant and on burst release.
- Grant edge: gnt, WE and DATA are loaded from the winner's slices.
  - WE = onehot(req_addr[winner]).
  - If req_lock[winner]=1 and MAXBURST>1: go to BURST, owner=winner, beat=1.
- BURST, each edge:
  - owner req=1, req_lock=1, beat<MAXBURST: regrant owner, resample addr/data, beat+1.
  - Otherwise: release. ptr=owner+1, state=IDLE, and arbitrate in the same edge with the new ptr, so there is no bubble.
  - If owner req=0 at the release edge, the owner does not write that cycle.
  - A dropped lock with req still high counts as a normal grant competing at the new ptr.
- No requests in IDLE: gnt=0, WE=0, DATA holds its last value.
- Work-conserving: a single requester asserting req every cycle is granted every cycle.
- busy = (state==BURST).

## Timing
- Request sampled at edge k → gnt/WE/DATA valid in cycle k..k+1 → register captures at edge k+1. Write latency is 2 edges from request.
- Requester keeps req, addr and data stable until it sees its gnt bit. The data written is whatever was sampled at the grant edge.
- Reset (reset=0, asynchronous, any state including mid-burst): gnt=0, WE=0, DATA=0, busy=0, ptr=0, beat=0, state=IDLE. First arbitration happens at the first edge after deassertion.
- WE has at most one bit set; gnt has at most one bit set; WE≠0 implies gnt≠0.
- Burst fairness: once a burst ends, the owner is lowest priority for the next arbitration.

## Structure
- Shared package regbank_pkg: state typedef (IDLE, BURST), onehot helper function, beat-counter width constant.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req vector and ptr; outputs are winner index and valid.
- Top level holds ptr, state, owner, beat and the output registers.

## Test plan
- Reset mid-burst: requester 1 in BURST with beat=2, assert reset=0 → all outputs 0 immediately; after release, req=001 → gnt=001.
- Round robin: req=111, lock=000 for 3 cycles → gnt sequence 001, 010, 100, then 001; WE follows each granted addr.
- Single write: req=010, addr1=2, data1=4'hA → one cycle later gnt=010, WE=0100, DATA=A; register 2 captures A at the next edge.
- Locked burst cap, MAXBURST=4: requester 0 holds req=1, lock=1, others also requesting → 4 consecutive gnt=001, then gnt=010 with no idle cycle.
- Early release: requester 2 drops lock after 2 beats while req=001 pending → third cycle gnt=001, ptr advances past 2, busy falls.
- Idle hold: after a write of 4'h5, req=000 → gnt=0, WE=0, DATA stays 5.
